outpass4_arbiter: RTL and testbench

OUTPASS4_ARBITER -- requirements
Module: outpass4_arbiter

---
 rtl/outpass4_arbiter.sv | 168 ++++++++++++++++
 tb/tb_outpass4_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/outpass4_arbiter.sv
// -----------------------------------------------------------------------------
// outpass4_arbiter
//
// Shares one 4-lane OutPass4 pad path among four requesters. Each requester
// offers one nibble per cycle. A round-robin arbiter picks an owner while the
// path is idle. The owner then streams a burst of nibbles onto the pads. After
// the burst, the path can insert an optional turnaround gap before the next
// arbitration.
//
// Parameters
//   MAX_BURST  : maximum transfers per grant (1..255)
//   IDLE_VALUE : value driven on pad_data when no nibble is presented
//   TURNAROUND : idle cycles inserted between bursts (0..15)
//
// Ports
//   clk       : single clock, all state changes on its rising edge
//   rst       : synchronous active-high reset
//   req_valid : bit n set when requester n holds a nibble
//   req_data  : nibble of requester n on bits [4n+3:4n]
//   req_last  : bit n marks requester n's nibble as the end of its burst
//   req_ready : one-hot or zero; bit n accepts requester n's nibble this cycle
//   grant     : registered one-hot owner of the pad path, zero when unowned
//   pad_data  : registered nibble driven onto OutPass4 inputs I0..I3
//   pad_valid : registered flag that pad_data carries an accepted nibble
//   busy      : high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module outpass4_arbiter #(
   parameter int unsigned MAX_BURST  = 8,
   parameter logic [3:0]  IDLE_VALUE = 4'h0,
   parameter int unsigned TURNAROUND = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req_valid,
   input  logic [15:0] req_data,
   input  logic [3:0]  req_last,
   output logic [3:0]  req_ready,
   output logic [3:0]  grant,
   output logic [3:0]  pad_data,
   output logic        pad_valid,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      GAP  = 2'd2
   } state_t;

   // The burst limit is compared in 9 bits, so a limit of 255 cannot wrap the
   // 8-bit counter before the comparison is made.
   localparam logic [8:0] MAX_BURST_W = 9'(MAX_BURST);
   localparam bit         HAS_GAP     = (TURNAROUND != 0);
   // The gap counter counts down to zero inclusive. Loading TURNAROUND-1
   // therefore gives exactly TURNAROUND cycles in GAP.
   localparam logic [3:0] GAP_LOAD    = HAS_GAP ? 4'(TURNAROUND - 1) : 4'd0;

   state_t      state;
   logic [1:0]  ptr;
   logic [7:0]  burst_cnt;
   logic [3:0]  gap_cnt;

   logic        win_found;
   logic [1:0]  win_idx;
   logic [1:0]  cand;

   logic        xfer_fire;
   logic [3:0]  cur_nibble;
   logic        cur_last;
   logic        count_full;
   logic        burst_end;

   // Round-robin winner search. The scan starts just above the previous owner
   // and wraps modulo 4, so the previous owner has the lowest priority. When
   // the offset is 4, it wraps to 0 and selects the previous owner itself.
   // That is the last choice considered.
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr;
      cand      = ptr;
      for (int i = 1; i <= 4; i++) begin
         cand = ptr + 2'(i);
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Ready is the registered grant, gated by the transfer state. It does not
   // depend on this cycle's inputs. A requester that is not granted therefore
   // never sees ready.
   assign req_ready = (state == XFER) ? grant : 4'b0000;
   assign busy      = (state != IDLE);

   // While a burst is active, ptr holds the current owner. It was loaded with
   // the winner when the grant was issued.
   assign xfer_fire  = |(req_valid & req_ready);
   assign cur_nibble = req_data[{ptr, 2'b00} +: 4];
   assign cur_last   = req_last[ptr];
   assign count_full = (({1'b0, burst_cnt} + 9'd1) == MAX_BURST_W);

   // A burst ends in any of three cases:
   //   - the owner stalls, so no transfer happens this cycle;
   //   - the owner flags its last nibble;
   //   - the transfer reaches the burst limit.
   // The last flag and the limit can both hold on the same transfer. That
   // still ends the burst only once.
   assign burst_end = !xfer_fire || cur_last || count_full;

   // Main sequencer. The pad outputs default to the idle value every cycle.
   // A transfer then overrides them, so each registered pad cycle reflects
   // only the transfer from the previous cycle. A synchronous reset abandons
   // any burst in flight. A nibble presented during the reset cycle is
   // discarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant     <= 4'b0000;
         ptr       <= 2'd3;
         burst_cnt <= 8'd0;
         gap_cnt   <= 4'd0;
         pad_data  <= IDLE_VALUE;
         pad_valid <= 1'b0;
      end else begin
         pad_data  <= IDLE_VALUE;
         pad_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  grant     <= 4'b0001 << win_idx;
                  ptr       <= win_idx;
                  burst_cnt <= 8'd0;
                  state     <= XFER;
               end
            end
            XFER: begin
               if (xfer_fire) begin
                  pad_data  <= cur_nibble;
                  pad_valid <= 1'b1;
                  burst_cnt <= burst_cnt + 8'd1;
               end
               if (burst_end) begin
                  grant <= 4'b0000;
                  if (HAS_GAP) begin
                     state   <= GAP;
                     gap_cnt <= GAP_LOAD;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == 4'd0) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt - 4'd1;
               end
            end
            default: begin
               state <= IDLE;
               grant <= 4'b0000;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_outpass4_arbiter.sv
// -----------------------------------------------------------------------------
// tb_outpass4_arbiter
//
// Drives three outpass4_arbiter instances from one shared stimulus stream.
// Each instance uses a different parameter set, so the default case, the
// no-gap case and a long gap with single-nibble bursts all see the same
// inputs. Each cycle, every output is compared with a behavioural model. The
// model tracks the owner, the nibble count, the cycles of gap left and the
// round-robin pointer as plain integers.
//
// Ports of the DUT: clk, rst, req_valid, req_data, req_last, req_ready,
// grant, pad_data, pad_valid, busy.
// -----------------------------------------------------------------------------
module tb_outpass4_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [15:0] req_data;
   logic [3:0]  req_last;

   logic [3:0]  readyO    [3];
   logic [3:0]  grantO    [3];
   logic [3:0]  padDataO  [3];
   logic        padValidO [3];
   logic        busyO     [3];

   int          maxbTab [3] = '{8, 3, 1};
   int          taTab   [3] = '{1, 0, 3};
   logic [3:0]  idleTab [3] = '{4'h0, 4'hA, 4'h5};

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   // owner < 0 means no grant; gapLeft > 0 means turnaround cycles remain
   typedef struct {
      int         owner;
      int         cnt;
      int         gapLeft;
      int         ptr;
      logic [3:0] padData;
      logic       padValid;
   } model_t;

   model_t m [3];

   outpass4_arbiter #(.MAX_BURST(8), .IDLE_VALUE(4'h0), .TURNAROUND(1)) dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(readyO[0]), .grant(grantO[0]),
      .pad_data(padDataO[0]), .pad_valid(padValidO[0]), .busy(busyO[0]));

   outpass4_arbiter #(.MAX_BURST(3), .IDLE_VALUE(4'hA), .TURNAROUND(0)) dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(readyO[1]), .grant(grantO[1]),
      .pad_data(padDataO[1]), .pad_valid(padValidO[1]), .busy(busyO[1]));

   outpass4_arbiter #(.MAX_BURST(1), .IDLE_VALUE(4'h5), .TURNAROUND(3)) dut2 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(readyO[2]), .grant(grantO[2]),
      .pad_data(padDataO[2]), .pad_valid(padValidO[2]), .busy(busyO[2]));

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance the behavioural model by one clock, given the inputs present
   // during the cycle.
   function automatic model_t modelStep(model_t s, int maxb, int ta, logic [3:0] idleVal,
                                        logic r, logic [3:0] v, logic [15:0] d, logic [3:0] l);
      model_t n;
      n = s;
      if (r) begin
         n.owner    = -1;
         n.cnt      = 0;
         n.gapLeft  = 0;
         n.ptr      = 3;
         n.padData  = idleVal;
         n.padValid = 1'b0;
         return n;
      end
      n.padData  = idleVal;
      n.padValid = 1'b0;
      if (s.owner >= 0) begin
         bit ended;
         ended = 1'b1;
         if (v[s.owner]) begin
            n.padData  = d[4*s.owner +: 4];
            n.padValid = 1'b1;
            n.cnt      = s.cnt + 1;
            ended      = l[s.owner] || (n.cnt == maxb);
         end
         if (ended) begin
            n.owner   = -1;
            n.gapLeft = ta;
         end
      end else if (s.gapLeft > 0) begin
         n.gapLeft = s.gapLeft - 1;
      end else begin
         for (int k = 1; k <= 4; k++) begin
            int c;
            c = (s.ptr + k) % 4;
            if (n.owner < 0 && v[c]) begin
               n.owner = c;
               n.ptr   = c;
               n.cnt   = 0;
            end
         end
      end
      return n;
   endfunction

   task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare every output of every instance against its model's current state
   task automatic checkAll();
      for (int k = 0; k < 3; k++) begin
         logic [3:0] expGrant;
         logic       expBusy;
         expGrant = (m[k].owner >= 0) ? 4'(1 << m[k].owner) : 4'b0000;
         expBusy  = (m[k].owner >= 0) || (m[k].gapLeft > 0);
         checkOutput($sformatf("dut%0d.grant@%0d", k, cycle), grantO[k], expGrant);
         checkOutput($sformatf("dut%0d.req_ready@%0d", k, cycle), readyO[k], expGrant);
         checkOutput($sformatf("dut%0d.pad_data@%0d", k, cycle), padDataO[k], m[k].padData);
         checkOutput($sformatf("dut%0d.pad_valid@%0d", k, cycle), {3'b000, padValidO[k]},
                     {3'b000, m[k].padValid});
         checkOutput($sformatf("dut%0d.busy@%0d", k, cycle), {3'b000, busyO[k]},
                     {3'b000, expBusy});
      end
   endtask

   // One cycle of stimulus. At the falling edge, check the settled outputs.
   // Then present the new inputs and advance the models past the next rising
   // edge.
   task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [15:0] d,
                                input logic [3:0] l);
      @(negedge clk);
      cycle++;
      checkAll();
      rst       = r;
      req_valid = v;
      req_data  = d;
      req_last  = l;
      for (int k = 0; k < 3; k++)
         m[k] = modelStep(m[k], maxbTab[k], taTab[k], idleTab[k], r, v, d, l);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 4'b0000;
      req_data  = 16'h0000;
      req_last  = 4'b0000;
      for (int k = 0; k < 3; k++)
         m[k] = modelStep(m[k], maxbTab[k], taTab[k], idleTab[k], 1'b1, 4'b0, 16'h0, 4'b0);

      // Reset state, then release
      applyStimulus(1'b1, 4'b0000, 16'h0000, 4'b0000);
      applyStimulus(1'b0, 4'b0000, 16'h0000, 4'b0000);

      // Single requester 0, nibbles 1,2,3 with last on 3
      applyStimulus(1'b0, 4'b0001, 16'h0001, 4'b0000);
      applyStimulus(1'b0, 4'b0001, 16'h0001, 4'b0000);
      applyStimulus(1'b0, 4'b0001, 16'h0002, 4'b0000);
      applyStimulus(1'b0, 4'b0001, 16'h0003, 4'b0001);
      for (int i = 0; i < 6; i++)
         applyStimulus(1'b0, 4'b0000, 16'h0000, 4'b0000);

      // All four requesters valid, last on the second nibble of each burst
      // (timed from the default instance's model)
      for (int i = 0; i < 30; i++) begin
         logic [3:0] lastNow;
         lastNow = (m[0].owner >= 0 && m[0].cnt == 1) ? 4'hF : 4'h0;
         applyStimulus(1'b0, 4'hF, 16'($urandom), lastNow);
      end

      // Requester 2 alone, never last: burst capped by MAX_BURST
      for (int i = 0; i < 24; i++)
         applyStimulus(1'b0, 4'b0100, 16'($urandom), 4'b0000);
      // Then requester 0 joins, so the re-grant alternates
      for (int i = 0; i < 24; i++)
         applyStimulus(1'b0, 4'b0101, 16'($urandom), 4'b0000);

      // From reset, requester 1 wins, drops valid after 2 nibbles, requester 3 waits
      applyStimulus(1'b1, 4'b0000, 16'h0000, 4'b0000);
      applyStimulus(1'b0, 4'b1010, 16'h7C5E, 4'b0000);
      applyStimulus(1'b0, 4'b1010, 16'h8D6F, 4'b0000);
      applyStimulus(1'b0, 4'b1010, 16'h9E70, 4'b0000);
      for (int i = 0; i < 10; i++)
         applyStimulus(1'b0, 4'b1000, 16'($urandom), 4'b0000);

      // Requesters 0 and 1, last on every nibble (no-gap path in dut1)
      applyStimulus(1'b1, 4'b0000, 16'h0000, 4'b0000);
      for (int i = 0; i < 12; i++)
         applyStimulus(1'b0, 4'b0011, 16'($urandom), 4'b1111);

      // Reset pulsed during the 3rd nibble of a burst, with a nibble presented
      applyStimulus(1'b1, 4'b0000, 16'h0000, 4'b0000);
      applyStimulus(1'b0, 4'b0011, 16'h0011, 4'b0000);
      applyStimulus(1'b0, 4'b0011, 16'h0022, 4'b0000);
      applyStimulus(1'b0, 4'b0011, 16'h0033, 4'b0000);
      applyStimulus(1'b1, 4'b0011, 16'h0044, 4'b0000);
      for (int i = 0; i < 8; i++)
         applyStimulus(1'b0, 4'b1100, 16'($urandom), 4'b0000);

      // Randomised traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         logic       r;
         logic [3:0] v;
         logic [3:0] l;
         r = ($urandom_range(63) == 0);
         v = 4'($urandom) | 4'($urandom);
         l = 4'($urandom) & 4'($urandom);
         applyStimulus(r, v, 16'($urandom), l);
      end

      // Final check of the last cycle's outputs
      applyStimulus(1'b0, 4'b0000, 16'h0000, 4'b0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
